// File: rtl/xfer_bus_pkg.sv
// Shared definitions for the register-bus transfer sequencer: FSM state
// encoding and command record sizing.
package xfer_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_LOAD  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // A queued command is packed as {src, dst}.
  function automatic int unsigned cmd_width(input int unsigned selw);
    return 2 * selw;
  endfunction

endpackage

// File: rtl/xfer_cmd_fifo.sv
// Circular command FIFO (DEPTH x W, DEPTH a power of two) with push/pop,
// full/empty flags and an occupancy count; push when full and pop when empty are ignored.
module xfer_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/xfer_bus_ctrl.sv
// Tristate register-bus transfer sequencer: queues src->dst commands and
// drives one T (tx_en) with a settle cycle before the ld_en strobe.
// Optional statistics counters under `XFER_BUS_CTRL_STATS_EN.
module xfer_bus_ctrl
  import xfer_bus_pkg::*;
#(
  parameter int unsigned NREG  = 8,
  parameter int unsigned SELW  = 3,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [SELW-1:0] cmd_src,
  input  logic [SELW-1:0] cmd_dst,
  output logic [NREG-1:0] tx_en,
  output logic [NREG-1:0] ld_en,
  output logic            busy,
  output logic            done,
  output logic            err
`ifdef XFER_BUS_CTRL_STATS_EN
  ,
  output logic [15:0]     xfer_count,
  output logic [7:0]      err_count
`endif
);

  localparam int unsigned    CW     = cmd_width(SELW);
  localparam int unsigned    QCW    = $clog2(DEPTH) + 1;
  localparam logic [SELW:0]  NREG_W = (SELW+1)'(NREG);
  localparam logic [NREG-1:0] ONE   = NREG'(1);

  state_t          state;
  state_t          state_nx;
  logic            push;
  logic            pop;
  logic            q_full;
  logic            q_empty;
  logic [QCW-1:0]  q_count;
  logic [CW-1:0]   q_head;
  logic [SELW-1:0] head_src;
  logic [SELW-1:0] head_dst;
  logic            head_ok;
  logic [SELW-1:0] src_q;
  logic [SELW-1:0] dst_q;
  logic            ok_q;

  assign cmd_ready = !q_full;
  assign push      = cmd_valid && !q_full;
  assign {head_src, head_dst} = q_head;
  assign head_ok   = ({1'b0, head_src} < NREG_W) && ({1'b0, head_dst} < NREG_W)
                     && (head_src != head_dst);
  assign busy      = (state != S_IDLE) || (q_count != '0);

  xfer_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({cmd_src, cmd_dst}),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  // Validity is resolved once at pop so the bus decode only needs ok_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      src_q <= '0;
      dst_q <= '0;
      ok_q  <= 1'b0;
    end else begin
      state <= state_nx;
      if (pop) begin
        src_q <= head_src;
        dst_q <= head_dst;
        ok_q  <= head_ok;
      end
    end
  end

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (!q_empty) begin
          pop      = 1'b1;
          state_nx = S_DRIVE;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_DRIVE: state_nx = S_LOAD;
      S_LOAD:  state_nx = S_DONE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    tx_en = '0;
    ld_en = '0;
    done  = 1'b0;
    err   = 1'b0;
    case (state)
      S_DRIVE: begin
        if (ok_q) tx_en = ONE << src_q;
      end
      S_LOAD: begin
        if (ok_q) begin
          tx_en = ONE << src_q;
          ld_en = ONE << dst_q;
        end
      end
      S_DONE: begin
        done = 1'b1;
        err  = !ok_q;
      end
      default: ;
    endcase
  end

`ifdef XFER_BUS_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_count <= '0;
      err_count  <= '0;
    end else if (state == S_DONE) begin
      if (ok_q)                 xfer_count <= xfer_count + 16'd1;
      else if (err_count != '1) err_count  <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xfer_bus_ctrl.sv
// Self-checking bench for xfer_bus_ctrl: directed and random commands checked
// each cycle against a timeline model of accept/done times.
module tb_xfer_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_src;
  logic [3:0] cmd_dst;
  logic [7:0] tx_en;
  logic [7:0] ld_en;
  logic       busy;
  logic       done;
  logic       err;
`ifdef XFER_BUS_CTRL_STATS_EN
  logic [15:0] xfer_count;
  logic [7:0]  err_count;
`endif

  xfer_bus_ctrl #(
    .NREG  (8),
    .SELW  (4),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_src   (cmd_src),
    .cmd_dst   (cmd_dst),
    .tx_en     (tx_en),
    .ld_en     (ld_en),
    .busy      (busy),
    .done      (done),
    .err       (err)
`ifdef XFER_BUS_CTRL_STATS_EN
    ,
    .xfer_count (xfer_count),
    .err_count  (err_count)
`endif
  );

  always #5 clk = ~clk;

  // Each accepted command: accept edge a, done cycle d = max(a+3, prev_d+3).
  // It drives in cycle d-2, loads in d-1, and sits in the queue for a..d-3.
  typedef struct {
    int src;
    int dst;
    int a;
    int d;
    bit ok;
  } xfer_t;

  xfer_t q[$];
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  bit    check_en = 1'b0;
  bit    last_acc;
  bit    exp_ready;

  function automatic int last_d();
    if (q.size() == 0) return -100;
    return q[q.size()-1].d;
  endfunction

  task automatic check_cycle();
    logic [7:0] one8 = 8'h01;
    logic [7:0] etx = '0;
    logic [7:0] eld = '0;
    logic       edone = 1'b0;
    logic       eerr = 1'b0;
    logic       ebusy = 1'b0;
    int         inq = 0;
    int         nok = 0;
    int         nerr = 0;
    foreach (q[i]) begin
      if (q[i].a <= cyc && cyc <= q[i].d) ebusy = 1'b1;
      if (q[i].a <= cyc && cyc < q[i].d - 2) inq++;
      if (q[i].ok && (cyc == q[i].d - 2 || cyc == q[i].d - 1)) etx = one8 << q[i].src;
      if (q[i].ok && cyc == q[i].d - 1) eld = one8 << q[i].dst;
      if (cyc == q[i].d) begin
        edone = 1'b1;
        eerr  = !q[i].ok;
      end
      if (q[i].d < cyc) begin
        if (q[i].ok) nok++;
        else         nerr++;
      end
    end
    exp_ready = (inq < 4);
    if (!check_en) return;

    tests++;
    assert (tx_en === etx) else begin
      fails++; $error("FAIL tx_en cyc=%0d observed=%h expected=%h", cyc, tx_en, etx);
    end
    tests++;
    assert (ld_en === eld) else begin
      fails++; $error("FAIL ld_en cyc=%0d observed=%h expected=%h", cyc, ld_en, eld);
    end
    tests++;
    assert (done === edone) else begin
      fails++; $error("FAIL done cyc=%0d observed=%b expected=%b", cyc, done, edone);
    end
    tests++;
    assert (err === eerr) else begin
      fails++; $error("FAIL err cyc=%0d observed=%b expected=%b", cyc, err, eerr);
    end
    tests++;
    assert (busy === ebusy) else begin
      fails++; $error("FAIL busy cyc=%0d observed=%b expected=%b", cyc, busy, ebusy);
    end
    tests++;
    assert (cmd_ready === exp_ready) else begin
      fails++; $error("FAIL cmd_ready cyc=%0d observed=%b expected=%b", cyc, cmd_ready, exp_ready);
    end
    tests++;
    assert (($countones(tx_en) <= 1) && ($countones(ld_en) <= 1) && ((tx_en & ld_en) == '0)
            && (ld_en == '0 || tx_en != '0)) else begin
      fails++; $error("FAIL bus_invariant cyc=%0d observed tx=%h ld=%h expected onehot-or-zero, disjoint", cyc, tx_en, ld_en);
    end
`ifdef XFER_BUS_CTRL_STATS_EN
    tests++;
    assert (xfer_count === 16'(nok)) else begin
      fails++; $error("FAIL xfer_count cyc=%0d observed=%0d expected=%0d", cyc, xfer_count, 16'(nok));
    end
    tests++;
    assert (err_count === 8'((nerr > 255) ? 255 : nerr)) else begin
      fails++; $error("FAIL err_count cyc=%0d observed=%0d expected=%0d", cyc, err_count, nerr);
    end
`endif
  endtask

  task automatic step(input bit v, input logic [3:0] s, input logic [3:0] d, input bit r);
    xfer_t x;
    cmd_valid = v;
    cmd_src   = s;
    cmd_dst   = d;
    rst       = r;
    #1;
    check_cycle();
    last_acc = v && !r && exp_ready;
    @(posedge clk);
    cyc++;
    if (r) begin
      q.delete();
    end else if (last_acc) begin
      x.src = int'(s);
      x.dst = int'(d);
      x.a   = cyc;
      x.d   = (cyc + 3 > last_d() + 3) ? cyc + 3 : last_d() + 3;
      x.ok  = (s < 8) && (d < 8) && (s != d);
      q.push_back(x);
    end
    #1;
  endtask

  task automatic push(input logic [3:0] s, input logic [3:0] d);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      step(1'b1, s, d, 1'b0);
      got = last_acc;
    end
    tests++;
    assert (got) else begin
      fails++; $error("FAIL push_timeout cyc=%0d observed=not accepted expected=accepted", cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  task automatic idle_until(input int target);
    for (int i = 0; i < 40 && cyc < target; i++) step(1'b0, 4'd0, 4'd0, 1'b0);
    tests++;
    assert (cyc == target) else begin
      fails++; $error("FAIL wait_cycle observed=%0d expected=%0d", cyc, target);
    end
  endtask

  initial begin
    int idx;
    logic [3:0] rs;
    logic [3:0] rd;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_src = '0;
    cmd_dst = '0;
    step(1'b0, 4'd0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 1'b1);
    check_en = 1'b1;

    idle(2);
    push(4'd2, 4'd5);
    idle(6);

    for (int i = 0; i < 6; i++) push(4'(i), 4'((i + 3) % 8));
    idle(22);

    push(4'd3, 4'd3);
    push(4'd9, 4'd1);
    idle(10);

    idx = q.size();
    push(4'd1, 4'd4);
    push(4'd2, 4'd6);
    push(4'd3, 4'd7);
    idle_until(q[idx].d - 1);
    step(1'b0, 4'd0, 4'd0, 1'b1);
    idle(6);

    idx = q.size();
    push(4'd0, 4'd1);
    push(4'd1, 4'd2);
    idle_until(q[idx].d);
    push(4'd2, 4'd3);
    idle(12);

    for (int i = 0; i < 80; i++) begin
      rs = 4'($urandom_range(0, 9));
      rd = ($urandom_range(0, 5) == 0) ? rs : 4'($urandom_range(0, 9));
      step(1'($urandom_range(0, 1)), rs, rd, 1'b0);
    end
    idle(25);

    step(1'b0, 4'd0, 4'd0, 1'b1);
    push(4'd0, 4'd7);
    push(4'd7, 4'd0);
    push(4'd5, 4'd5);
    push(4'd4, 4'd6);
    idle(16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
